// File: rtl/requantize_multi_if.sv
// Stream, configuration and status signals of the multi-channel requantizer.
// The master side feeds samples and configuration; the slave side is the requantizer.
interface requantize_multi_if #(
   parameter int WIDTH = 18,
   parameter int CHW   = 2,
   parameter int QW    = 5,
   parameter int CNTW  = 16
);
   logic             cfg_we;
   logic [CHW-1:0]   cfg_chan;
   logic [QW-1:0]    cfg_nquant;
   logic [1:0]       cfg_mode;

   logic             in_valid;
   logic             in_ready;
   logic [CHW-1:0]   in_chan;
   logic [WIDTH-1:0] datain;

   logic             out_valid;
   logic             out_ready;
   logic [CHW-1:0]   out_chan;
   logic [WIDTH-1:0] dataout;
   logic             out_sat;

   logic             sat_clr;
   logic [CNTW-1:0]  sat_count;

   modport master (
      output cfg_we, cfg_chan, cfg_nquant, cfg_mode,
      output in_valid, in_chan, datain,
      output out_ready, sat_clr,
      input  in_ready, out_valid, out_chan, dataout, out_sat, sat_count
   );

   modport slave (
      input  cfg_we, cfg_chan, cfg_nquant, cfg_mode,
      input  in_valid, in_chan, datain,
      input  out_ready, sat_clr,
      output in_ready, out_valid, out_chan, dataout, out_sat, sat_count
   );
endinterface

// File: rtl/requantize_multi.sv
// Multi-channel requantizer: per-channel output width and rounding mode,
// saturation on positive overflow, a saturation event counter and a
// 2-stage stallable valid/ready pipeline.
module requantize_multi #(
   parameter int WIDTH = 18,
   parameter int NCH   = 4,
   parameter int CHW   = 2,
   parameter int QW    = 5,
   parameter int CNTW  = 16
) (
   input logic              clock,
   input logic              reset,
   requantize_multi_if.slave bus
);
   localparam int XW = WIDTH + 1;

   logic [QW-1:0]    q_cfg    [NCH];
   logic [1:0]       mode_cfg [NCH];

   logic             s1_valid;
   logic [CHW-1:0]   s1_chan;
   logic [QW-1:0]    s1_q;
   logic [1:0]       s1_mode;
   logic [WIDTH-1:0] s1_fl;
   logic             s1_gt;
   logic             s1_eq;

   logic             s1_load;
   logic             s2_load;
   logic [QW-1:0]    q_wr;
   logic [CHW-1:0]   rd_idx;
   logic [QW-1:0]    q_rd;
   logic [1:0]       mode_rd;
   int               sh;
   logic [WIDTH-1:0] fl_c;
   logic [WIDTH-1:0] mask_c;
   logic [WIDTH-1:0] frac_c;
   logic [WIDTH-1:0] half_c;
   logic             gt_c;
   logic             eq_c;

   logic             inc;
   logic [XW-1:0]    r_ext;
   logic [XW-1:0]    max_ext;
   logic             sat_c;
   logic [WIDTH-1:0] res_c;

   // Pipeline advance: a stage loads when it is empty or its successor is loading.
   always_comb begin
      s2_load      = !bus.out_valid || bus.out_ready;
      s1_load      = !s1_valid || s2_load;
      bus.in_ready = s1_load;
   end

   // Written Q is clamped to 2..WIDTH so the datapath never sees a degenerate width.
   always_comb begin
      if (int'(bus.cfg_nquant) < 2) begin
         q_wr = QW'(2);
      end else if (int'(bus.cfg_nquant) > WIDTH) begin
         q_wr = QW'(WIDTH);
      end else begin
         q_wr = bus.cfg_nquant;
      end
   end

   // Per-channel configuration; writes to nonexistent channels are dropped.
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < NCH; i++) begin
            q_cfg[i]    <= QW'(WIDTH);
            mode_cfg[i] <= 2'd0;
         end
      end else if (bus.cfg_we && (int'(bus.cfg_chan) < NCH)) begin
         q_cfg[bus.cfg_chan]    <= q_wr;
         mode_cfg[bus.cfg_chan] <= bus.cfg_mode;
      end
   end

   // Stage 1 arithmetic: floor shift plus comparison of the dropped bits against one half.
   always_comb begin
      rd_idx  = (int'(bus.in_chan) < NCH) ? bus.in_chan : '0;
      q_rd    = q_cfg[rd_idx];
      mode_rd = mode_cfg[rd_idx];
      sh      = WIDTH - int'(q_rd);
      fl_c    = WIDTH'($signed(bus.datain) >>> sh);
      mask_c  = (WIDTH'(1) << sh) - WIDTH'(1);
      frac_c  = bus.datain & mask_c;
      half_c  = '0;
      if (sh > 0) begin
         half_c = WIDTH'(1) << (sh - 1);
      end
      gt_c = (sh > 0) && (frac_c > half_c);
      eq_c = (sh > 0) && (frac_c == half_c);
   end

   // Stage 1 register captures the sample together with the config in force at acceptance.
   always_ff @(posedge clock) begin
      if (reset) begin
         s1_valid <= 1'b0;
         s1_chan  <= '0;
         s1_q     <= QW'(WIDTH);
         s1_mode  <= 2'd0;
         s1_fl    <= '0;
         s1_gt    <= 1'b0;
         s1_eq    <= 1'b0;
      end else if (s1_load) begin
         s1_valid <= bus.in_valid;
         if (bus.in_valid) begin
            s1_chan <= bus.in_chan;
            s1_q    <= q_rd;
            s1_mode <= mode_rd;
            s1_fl   <= fl_c;
            s1_gt   <= gt_c;
            s1_eq   <= eq_c;
         end
      end
   end

   // Stage 2 arithmetic: rounding increment with one guard bit, then clip at the positive limit.
   always_comb begin
      case (s1_mode)
         2'd1:    inc = s1_gt | s1_eq;
         2'd2:    inc = s1_gt | (s1_eq & s1_fl[0]);
         default: inc = 1'b0;
      endcase
      r_ext   = {s1_fl[WIDTH-1], s1_fl} + {{WIDTH{1'b0}}, inc};
      max_ext = (XW'(1) << (s1_q - QW'(1))) - XW'(1);
      sat_c   = $signed(r_ext) > $signed(max_ext);
      res_c   = sat_c ? max_ext[WIDTH-1:0] : r_ext[WIDTH-1:0];
   end

   // Output register holds steady while the consumer stalls.
   always_ff @(posedge clock) begin
      if (reset) begin
         bus.out_valid <= 1'b0;
         bus.out_chan  <= '0;
         bus.dataout   <= '0;
         bus.out_sat   <= 1'b0;
      end else if (s2_load) begin
         bus.out_valid <= s1_valid;
         if (s1_valid) begin
            bus.out_chan <= s1_chan;
            bus.dataout  <= res_c;
            bus.out_sat  <= sat_c;
         end
      end
   end

   // Saturation event counter sticks at all-ones; clear wins over a coincident increment.
   always_ff @(posedge clock) begin
      if (reset || bus.sat_clr) begin
         bus.sat_count <= '0;
      end else if (bus.out_valid && bus.out_ready && bus.out_sat && (bus.sat_count != '1)) begin
         bus.sat_count <= bus.sat_count + CNTW'(1);
      end
   end
endmodule
